// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit. It detects load-use hazards and HI/LO
// hazards behind a busy multiply/divide unit (MDU), and gives a taken branch
// priority over both. It also tracks MDU busy time and counts stalled cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rs_if_id, rt_if_id  source fields of the IF/ID instruction
//   rs_used_if_id,
//   rt_used_if_id       the IF/ID instruction reads rs / rt
//   mem_rd_id_ex        the ID/EX instruction is a load
//   rt_id_ex            load destination register in ID/EX
//   md_start_id_ex      the ID/EX instruction issues a mul/div
//   md_use_if_id        the IF/ID instruction touches HI/LO
//   branch_taken_ex     a branch or jump resolved taken in EX
//   pc_wr_en,
//   if_id_wr_en         PC and IF/ID load enables
//   if_id_flush         zeroes IF/ID at the next edge
//   id_ex_bubble        loads a NOP into ID/EX at the next edge
//   md_busy, md_done    MDU is busy / MDU is in its last busy cycle
//   stall_cnt           saturating count of cycles with the PC held
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_if_id,
  input  logic [4:0]  rt_if_id,
  input  logic        rs_used_if_id,
  input  logic        rt_used_if_id,
  input  logic        mem_rd_id_ex,
  input  logic [4:0]  rt_id_ex,
  input  logic        md_start_id_ex,
  input  logic        md_use_if_id,
  input  logic        branch_taken_ex,
  output logic        pc_wr_en,
  output logic        if_id_wr_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [STAT_W-1:0]   r_stall_cnt;

  logic w_load_use;
  logic w_md_stall;

  // MDU state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // MDU next state; a new start always restarts the full latency
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (md_start_id_ex) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_W'(MDU_LAT);
        end
      end
      S_BUSY: begin
        if (md_start_id_ex) begin
          w_cnt_nxt = CNT_W'(MDU_LAT);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (r_state == S_BUSY);
  assign md_done = md_busy && (r_cnt == CNT_W'(1));

  // Hazard detection; $0 never creates a dependency
  assign w_load_use = mem_rd_id_ex && (rt_id_ex != 5'd0) &&
                      ((rs_used_if_id && (rs_if_id == rt_id_ex)) ||
                       (rt_used_if_id && (rt_if_id == rt_id_ex)));
  assign w_md_stall = md_busy && md_use_if_id;

  // Pipeline control: branch beats stalls; reset forces normal flow
  always_comb begin
    pc_wr_en     = 1'b1;
    if_id_wr_en  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst) begin
      if (branch_taken_ex) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_load_use || w_md_stall) begin
        pc_wr_en     = 1'b0;
        if_id_wr_en  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!pc_wr_en && (r_stall_cnt != {STAT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 4, meaning the number of busy cycles of the multiply/divide unit; legal range 2..15.
REQ-002 clk  input  1  the single pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rs_if_id  input  5  rs field of the instruction in IF/ID.
REQ-005 rt_if_id  input  5  rt field of the instruction in IF/ID.
REQ-006 rs_used_if_id  input  1  the IF/ID instruction reads rs.
REQ-007 rt_used_if_id  input  1  the IF/ID instruction reads rt.
REQ-008 mem_rd_id_ex  input  1  the ID/EX instruction is a load.
REQ-009 rt_id_ex  input  5  destination register of the ID/EX load.
REQ-010 md_start_id_ex  input  1  the ID/EX instruction issues a mul/div.
REQ-011 md_use_if_id  input  1  the IF/ID instruction touches HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
REQ-012 branch_taken_ex  input  1  a branch or jump resolved taken in EX this cycle.
REQ-013 pc_wr_en  output  1  PC load enable.
REQ-014 if_id_wr_en  output  1  IF/ID register load enable.
REQ-015 if_id_flush  output  1  zeroes IF/ID at the next edge.
REQ-016 id_ex_bubble  output  1  loads a NOP into ID/EX at the next edge.
REQ-017 md_busy  output  1  the MDU is computing.
REQ-018 md_done  output  1  the last busy cycle of the MDU.
REQ-019 stall_cnt  output  16  count of stalled cycles.

Function
REQ-020 load_use SHALL be mem_rd_id_ex & (rt_id_ex != 0) & ((rs_used_if_id & rs_if_id == rt_id_ex) | (rt_used_if_id & rt_if_id == rt_id_ex)), evaluated combinationally.
REQ-021 md_stall SHALL be md_busy & md_use_if_id, evaluated combinationally.
REQ-022 Priority SHALL be branch_taken_ex, then load_use, then md_stall, then normal flow.
REQ-023 Branch case: pc_wr_en=1, if_id_wr_en=1, if_id_flush=1, id_ex_bubble=1; any stall condition is ignored in that cycle.
REQ-024 Stall case (load_use or md_stall without branch): pc_wr_en=0, if_id_wr_en=0, if_id_flush=0, id_ex_bubble=1.
REQ-025 Normal case: pc_wr_en=1, if_id_wr_en=1, if_id_flush=0, id_ex_bubble=0.
REQ-026 Load-use stall lasts exactly 1 cycle with no internal state; the bubble in EX clears the condition.
REQ-027 MDU FSM states: IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-028 IDLE: md_start_id_ex=1 at an edge SHALL move the FSM to BUSY and load cnt=MDU_LAT; otherwise it stays in IDLE.
REQ-029 BUSY: each edge decrements cnt; cnt==1 at an edge SHALL return the FSM to IDLE.
REQ-030 md_start_id_ex=1 in BUSY SHALL reload cnt=MDU_LAT and keep the FSM in BUSY; this is a restart, not a queue.
REQ-031 md_busy SHALL be 1 iff the state is BUSY; it is high for exactly MDU_LAT consecutive cycles after the issuing edge.
REQ-032 md_done SHALL be (state==BUSY) & (cnt==1), combinational.
REQ-033 An IF/ID instruction stalled by md_stall SHALL advance in the first cycle after md_busy falls.
REQ-034 branch_taken_ex SHALL NOT abort a running MDU operation; the FSM keeps counting.
REQ-035 stall_cnt SHALL increment by 1 at every edge where pc_wr_en=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-036 rst=1 SHALL force, immediately and asynchronously, state=IDLE, cnt=0, and stall_cnt=0.
REQ-037 While rst=1 the outputs SHALL be md_busy=0, md_done=0, pc_wr_en=1, if_id_wr_en=1, if_id_flush=0, id_ex_bubble=0.
REQ-038 rst asserted mid-MDU operation SHALL discard the operation; after release the FSM is in IDLE and a pending md_use_if_id does not stall.

Verification
REQ-039 Load-use: mem_rd_id_ex=1, rt_id_ex=5, rs_if_id=5, rs_used_if_id=1 -> pc_wr_en=0 and id_ex_bubble=1 for one cycle, and stall_cnt increases by 1.
REQ-040 Register $0 and unused operands: rt_id_ex=0, or a matching field with its *_used=0 -> no stall.
REQ-041 MDU with MDU_LAT=4: md_start pulsed at cycle 0 and md_use_if_id=1 held -> md_busy=1 in cycles 1-4, md_done=1 in cycle 4, stall in cycles 1-4, advance in cycle 5.
REQ-042 Simultaneous: branch_taken_ex=1 together with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_wr_en=1, and stall_cnt is unchanged.
REQ-043 Saturation: preload the stall count by holding a stall for 65540 cycles -> stall_cnt holds at 16'hFFFF.
REQ-044 Reset mid-operation: rst pulsed in cycle 2 of an MDU operation -> md_busy=0 immediately, stall_cnt=0, and no stall after release.
